// File: rtl/dec_stage_p.sv
// Registered decode stage between FETCH and EXE: field split, register-file read with
// write-through bypass, load-use hazard stall, and a valid/ready output register with flush.
module dec_stage_p #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int ZERO_R0    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instruction,
    input  logic [31:0]           pc_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic [3:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  wb_wen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] rs1_val,
    output logic [DATA_WIDTH-1:0] rs2_val,
    output logic [1:0]            instr_type,
    output logic [3:0]            rs1,
    output logic [3:0]            rs2,
    output logic [3:0]            rd,
    output logic [DATA_WIDTH-1:0] se_imm,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  needs_wb,
    output logic                  is_computational,
    output logic [31:0]           pc_out,
    output logic [15:0]           stall_count
);

    localparam logic [4:0] NREGS = 5'(NUM_REGS);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rs1_val;
        logic [DATA_WIDTH-1:0] rs2_val;
        logic [DATA_WIDTH-1:0] se_imm;
        logic [31:0]           pc;
        logic [1:0]            itype;
        logic [3:0]            rs1;
        logic [3:0]            rs2;
        logic [3:0]            rd;
        logic                  is_load;
        logic                  is_store;
        logic                  needs_wb;
        logic                  is_comp;
    } bundle_t;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    bundle_t     bundle_q, bundle_d, dec;
    logic        out_valid_q, out_valid_d;
    logic [15:0] stall_q, stall_d;
    logic [3:0]  opcode;
    logic        wb_legal, rs2_used, hazard;

    // Register-file read: same-cycle write-back wins, R0 may be hard-wired, unimplemented reads 0.
    function automatic logic [DATA_WIDTH-1:0] rf_read(
        input logic [3:0]                          addr,
        input logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
        input logic                                byp_en,
        input logic [3:0]                          byp_addr,
        input logic [DATA_WIDTH-1:0]               byp_data
    );
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (byp_en && (byp_addr == addr)) begin
            val = byp_data;
        end else if ((ZERO_R0 != 0) && (addr == 4'd0)) begin
            val = '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr == 4'(i)) val = regs[i];
            end
        end
        return val;
    endfunction

    assign opcode   = instruction[31:28];
    assign wb_legal = wb_wen && ({1'b0, wb_addr} < NREGS) &&
                      !((ZERO_R0 != 0) && (wb_addr == 4'd0));
    assign rs2_used = ~opcode[3];

    // Decoded bundle for the offered instruction.
    always_comb begin
        dec          = '0;
        dec.itype    = opcode[3:2];
        dec.rd       = instruction[27:24];
        dec.rs1      = instruction[23:20];
        dec.rs2      = instruction[19:16];
        dec.se_imm   = DATA_WIDTH'($signed(instruction[15:0]));
        dec.pc       = pc_in;
        dec.is_load  = opcode[3] & opcode[0];
        dec.is_store = ~opcode[3] & opcode[0];
        dec.needs_wb = ~opcode[2];
        dec.is_comp  = opcode[1];
        dec.rs1_val  = rf_read(instruction[23:20], regs_q, wb_legal, wb_addr, wb_data);
        dec.rs2_val  = rf_read(instruction[19:16], regs_q, wb_legal, wb_addr, wb_data);
    end

    // Load-use hazard against the held bundle.
    always_comb begin
        hazard = out_valid_q && bundle_q.is_load && bundle_q.needs_wb &&
                 ((bundle_q.rd == dec.rs1) || (rs2_used && (bundle_q.rd == dec.rs2))) &&
                 !((ZERO_R0 != 0) && (bundle_q.rd == 4'd0));
        in_ready = flush | ((~out_valid_q | out_ready) & ~hazard);
    end

    // Register-file write port.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wb_legal && (wb_addr == 4'(i))) begin
                regs_d[i] = wb_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Output register priority: flush, accept, drain, hold; plus saturating stall counter.
    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            bundle_d    = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (in_valid && hazard && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q      <= '0;
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= 16'd0;
        end else begin
            regs_q      <= regs_d;
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign rs1_val          = bundle_q.rs1_val;
    assign rs2_val          = bundle_q.rs2_val;
    assign instr_type       = bundle_q.itype;
    assign rs1              = bundle_q.rs1;
    assign rs2              = bundle_q.rs2;
    assign rd               = bundle_q.rd;
    assign se_imm           = bundle_q.se_imm;
    assign is_load          = bundle_q.is_load;
    assign is_store         = bundle_q.is_store;
    assign needs_wb         = bundle_q.needs_wb;
    assign is_computational = bundle_q.is_comp;
    assign pc_out           = bundle_q.pc;
    assign stall_count      = stall_q;

endmodule

// File: tb/tb_dec_stage_p.sv
// Directed bench for dec_stage_p: default, ZERO_R0=1 and a narrow 8-register/16-bit
// instance share one stimulus stream; each task checks the instance it targets.
module tb_dec_stage_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, pc_in;
    logic        in_valid, flush, wb_wen, out_ready;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // default instance
    logic        a_in_ready, a_out_valid, a_is_load, a_is_store, a_needs_wb, a_is_comp;
    logic [31:0] a_rs1_val, a_rs2_val, a_se_imm, a_pc_out;
    logic [1:0]  a_itype;
    logic [3:0]  a_rs1, a_rs2, a_rd;
    logic [15:0] a_stall;
    // ZERO_R0 instance
    logic        z_in_ready, z_out_valid, z_is_load, z_is_store, z_needs_wb, z_is_comp;
    logic [31:0] z_rs1_val, z_rs2_val, z_se_imm, z_pc_out;
    logic [1:0]  z_itype;
    logic [3:0]  z_rs1, z_rs2, z_rd;
    logic [15:0] z_stall;
    // narrow instance
    logic        s_in_ready, s_out_valid, s_is_load, s_is_store, s_needs_wb, s_is_comp;
    logic [15:0] s_rs1_val, s_rs2_val, s_se_imm;
    logic [31:0] s_pc_out;
    logic [1:0]  s_itype;
    logic [3:0]  s_rs1, s_rs2, s_rd;
    logic [15:0] s_stall;

    dec_stage_p dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
        .in_valid(in_valid), .in_ready(a_in_ready), .flush(flush),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_wen(wb_wen),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .rs1_val(a_rs1_val), .rs2_val(a_rs2_val), .instr_type(a_itype),
        .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .se_imm(a_se_imm),
        .is_load(a_is_load), .is_store(a_is_store), .needs_wb(a_needs_wb),
        .is_computational(a_is_comp), .pc_out(a_pc_out), .stall_count(a_stall)
    );

    dec_stage_p #(.DATA_WIDTH(32), .NUM_REGS(16), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
        .in_valid(in_valid), .in_ready(z_in_ready), .flush(flush),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_wen(wb_wen),
        .out_valid(z_out_valid), .out_ready(out_ready),
        .rs1_val(z_rs1_val), .rs2_val(z_rs2_val), .instr_type(z_itype),
        .rs1(z_rs1), .rs2(z_rs2), .rd(z_rd), .se_imm(z_se_imm),
        .is_load(z_is_load), .is_store(z_is_store), .needs_wb(z_needs_wb),
        .is_computational(z_is_comp), .pc_out(z_pc_out), .stall_count(z_stall)
    );

    dec_stage_p #(.DATA_WIDTH(16), .NUM_REGS(8), .ZERO_R0(0)) dut_s (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
        .in_valid(in_valid), .in_ready(s_in_ready), .flush(flush),
        .wb_addr(wb_addr), .wb_data(wb_data[15:0]), .wb_wen(wb_wen),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .rs1_val(s_rs1_val), .rs2_val(s_rs2_val), .instr_type(s_itype),
        .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .se_imm(s_se_imm),
        .is_load(s_is_load), .is_store(s_is_store), .needs_wb(s_needs_wb),
        .is_computational(s_is_comp), .pc_out(s_pc_out), .stall_count(s_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        instruction = ins;
        pc_in       = pc;
        in_valid    = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instruction = 32'h0; pc_in = 32'h0; in_valid = 1'b0; flush = 1'b0;
        wb_wen = 1'b0; wb_addr = 4'h0; wb_data = 32'h0; out_ready = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", a_out_valid); end
        checks++; if (a_stall !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h exp 0", a_stall); end
        checks++; if (a_pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", a_pc_out); end
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", a_in_ready); end
    endtask

    task automatic test_basic();
        wb_wen = 1'b1; wb_addr = 4'd3; wb_data = 32'h1234;
        step();
        wb_wen = 1'b0;
        offer(32'h0033_0000, 32'h100);
        step();
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", a_out_valid); end
        checks++; if (a_rs1_val !== 32'h1234) begin errors++; $display("FAIL basic_rs1: got %h exp 1234", a_rs1_val); end
        checks++; if (a_rs2_val !== 32'h1234) begin errors++; $display("FAIL basic_rs2: got %h exp 1234", a_rs2_val); end
        checks++; if (a_needs_wb !== 1'b1 || a_itype !== 2'b00) begin errors++; $display("FAIL basic_dec: got wb=%b t=%b exp 1/00", a_needs_wb, a_itype); end
        checks++; if (a_pc_out !== 32'h100) begin errors++; $display("FAIL basic_pc: got %h exp 100", a_pc_out); end
    endtask

    task automatic test_bypass();
        offer(32'h8150_8001, 32'h104);
        wb_wen = 1'b1; wb_addr = 4'd5; wb_data = 32'hCAFE;
        step();
        wb_wen = 1'b0;
        checks++; if (a_rs1_val !== 32'hCAFE) begin errors++; $display("FAIL bypass_rs1: got %h exp cafe", a_rs1_val); end
        checks++; if (a_se_imm !== 32'hFFFF8001) begin errors++; $display("FAIL bypass_imm: got %h exp ffff8001", a_se_imm); end
        checks++; if (a_itype !== 2'b10 || a_rs1 !== 4'd5 || a_rd !== 4'd1) begin errors++; $display("FAIL bypass_fields: got t=%b rs1=%h rd=%h exp 10/5/1", a_itype, a_rs1, a_rd); end
        offer(32'h7055_0000, 32'h108);
        step();
        in_valid = 1'b0;
        checks++; if (a_rs1_val !== 32'hCAFE || a_rs2_val !== 32'hCAFE) begin errors++; $display("FAIL rf_write: got %h/%h exp cafe/cafe", a_rs1_val, a_rs2_val); end
        checks++; if ({a_is_load, a_is_store, a_needs_wb, a_is_comp} !== 4'b0101 || a_itype !== 2'b01) begin
            errors++; $display("FAIL store_flags: got %b t=%b exp 0101 t=01", {a_is_load, a_is_store, a_needs_wb, a_is_comp}, a_itype); end
    endtask

    task automatic test_load_use();
        offer(32'h9200_0000, 32'h10C);
        step();
        checks++; if (a_is_load !== 1'b1 || a_needs_wb !== 1'b1) begin errors++; $display("FAIL load_flags: got %b%b exp 11", a_is_load, a_needs_wb); end
        offer(32'h0120_0000, 32'h110);
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready: got %b exp 0", a_in_ready); end
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b exp 0", a_out_valid); end
        checks++; if (a_stall !== 16'd1) begin errors++; $display("FAIL lu_stall: got %0d exp 1", a_stall); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_after: got %b exp 1", a_in_ready); end
        step();
        checks++; if (a_out_valid !== 1'b1 || a_rs1 !== 4'd2 || a_rd !== 4'd1) begin errors++; $display("FAIL lu_accept: got v=%b rs1=%h rd=%h exp 1/2/1", a_out_valid, a_rs1, a_rd); end
        checks++; if (a_stall !== 16'd1) begin errors++; $display("FAIL lu_stall_once: got %0d exp 1", a_stall); end
    endtask

    task automatic test_no_stall();
        offer(32'h9200_0000, 32'h114);
        step();
        offer(32'h8032_0000, 32'h118);
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL itype_rs2_ready: got %b exp 1", a_in_ready); end
        step();
        checks++; if (a_out_valid !== 1'b1 || a_rs2 !== 4'd2 || a_stall !== 16'd1) begin errors++; $display("FAIL itype_no_stall: got v=%b rs2=%h st=%0d exp 1/2/1", a_out_valid, a_rs2, a_stall); end
        in_valid = 1'b0;
        wb_wen = 1'b1; wb_addr = 4'd0; wb_data = 32'h55;
        step();
        wb_wen = 1'b0;
        offer(32'h9000_0000, 32'h11C);
        step();
        offer(32'h0100_0000, 32'h120);
        #1;
        checks++; if (z_in_ready !== 1'b1) begin errors++; $display("FAIL z_ready: got %b exp 1", z_in_ready); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL r0_hazard_default: got %b exp 0", a_in_ready); end
        step();
        checks++; if (z_out_valid !== 1'b1 || z_rs1_val !== 32'h0 || z_stall !== 16'd1) begin errors++; $display("FAIL z_consumer: got v=%b val=%h st=%0d exp 1/0/1", z_out_valid, z_rs1_val, z_stall); end
        checks++; if (a_out_valid !== 1'b0 || a_stall !== 16'd2) begin errors++; $display("FAIL r0_stall_default: got v=%b st=%0d exp 0/2", a_out_valid, a_stall); end
        step();
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_rs1_val !== 32'h55) begin errors++; $display("FAIL r0_value_default: got v=%b val=%h exp 1/55", a_out_valid, a_rs1_val); end
    endtask

    task automatic test_hold_flush();
        step();
        offer(32'h0453_1234, 32'h200);
        out_ready = 1'b0;
        step();
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL hold_load: got %b exp 1", a_out_valid); end
        offer(32'h0677_0000, 32'h300);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b exp 0", i, a_in_ready); end
            step();
            checks++; if (a_out_valid !== 1'b1 || a_pc_out !== 32'h200 || a_rd !== 4'd4 || a_rs1_val !== 32'hCAFE ||
                          a_rs2_val !== 32'h1234 || a_se_imm !== 32'h1234) begin
                errors++; $display("FAIL hold_stable[%0d]: got v=%b pc=%h rd=%h a=%h b=%h i=%h exp 1/200/4/cafe/1234/1234",
                                   i, a_out_valid, a_pc_out, a_rd, a_rs1_val, a_rs2_val, a_se_imm); end
        end
        flush = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", a_in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b exp 0", a_out_valid); end
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b exp 0", a_out_valid); end
        offer(32'h9200_0000, 32'h400);
        step();
        offer(32'h0120_0000, 32'h404);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_stall !== 16'd2) begin errors++; $display("FAIL flush_hazard: got v=%b st=%0d exp 0/2", a_out_valid, a_stall); end
    endtask

    task automatic test_narrow_reset();
        wb_wen = 1'b1; wb_addr = 4'd6; wb_data = 32'h1357;
        step();
        wb_addr = 4'd12; wb_data = 32'hBEEF;
        offer(32'h01C6_8001, 32'h500);
        step();
        wb_wen = 1'b0;
        checks++; if (s_out_valid !== 1'b1 || s_rs1_val !== 16'h0 || s_rs2_val !== 16'h1357) begin errors++; $display("FAIL narrow_bypass_r12: got v=%b a=%h b=%h exp 1/0/1357", s_out_valid, s_rs1_val, s_rs2_val); end
        checks++; if (s_se_imm !== 16'h8001) begin errors++; $display("FAIL narrow_imm: got %h exp 8001", s_se_imm); end
        checks++; if (a_rs1_val !== 32'hBEEF) begin errors++; $display("FAIL wide_bypass_r12: got %h exp beef", a_rs1_val); end
        step();
        checks++; if (s_rs1_val !== 16'h0 || a_rs1_val !== 32'hBEEF) begin errors++; $display("FAIL r12_stored: got s=%h a=%h exp 0/beef", s_rs1_val, a_rs1_val); end
        offer(32'h9200_0000, 32'h600);
        step();
        offer(32'h0120_0000, 32'h604);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (s_out_valid !== 1'b0 || s_pc_out !== 32'h0 || s_se_imm !== 16'h0 || s_rs2_val !== 16'h0) begin
            errors++; $display("FAIL mid_reset_narrow: got v=%b pc=%h i=%h b=%h exp all 0", s_out_valid, s_pc_out, s_se_imm, s_rs2_val); end
        checks++; if (a_out_valid !== 1'b0 || a_stall !== 16'd0 || a_rd !== 4'd0 || a_is_load !== 1'b0) begin
            errors++; $display("FAIL mid_reset_wide: got v=%b st=%0d rd=%h ld=%b exp all 0", a_out_valid, a_stall, a_rd, a_is_load); end
        rst = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b exp 1", a_in_ready); end
        offer(32'h0060_0000, 32'h700);
        step();
        in_valid = 1'b0;
        checks++; if (s_rs1_val !== 16'h0 || a_rs1_val !== 32'h0 || a_out_valid !== 1'b1) begin
            errors++; $display("FAIL regs_cleared: got s=%h a=%h v=%b exp 0/0/1", s_rs1_val, a_rs1_val, a_out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_load_use();
        test_no_stall();
        test_hold_flush();
        test_narrow_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
